// File: rtl/keypad_display_io.sv
// Front-panel I/O: 4x4 keypad scan/debounce with ready/ack handshake, 4-digit 7-seg mux.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module keypad_display_io #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REFRESH_DIV    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  rowwrite,
    input  logic [3:0]  colread,
    output logic [3:0]  keyout,
    output logic        ready,
    input  logic        ack,
    input  logic [15:0] datain,
    output logic [3:0]  grounds,
    output logic [6:0]  display
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_SCANS);

    function automatic logic [3:0] key_code(input logic [3:0] rc);
        case (rc)
            4'd0:    key_code = 4'h1;
            4'd1:    key_code = 4'h2;
            4'd2:    key_code = 4'h3;
            4'd3:    key_code = 4'hA;
            4'd4:    key_code = 4'h4;
            4'd5:    key_code = 4'h5;
            4'd6:    key_code = 4'h6;
            4'd7:    key_code = 4'hB;
            4'd8:    key_code = 4'h7;
            4'd9:    key_code = 4'h8;
            4'd10:   key_code = 4'h9;
            4'd11:   key_code = 4'hC;
            4'd12:   key_code = 4'hE;
            4'd13:   key_code = 4'h0;
            4'd14:   key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
    endfunction

    logic [SW-1:0] scan_cnt;
    logic [1:0]    row;
    logic          cand_v, prev_v, stable_v;
    logic [3:0]    cand_code, prev_code, stable_code;
    logic [DW-1:0] db_cnt, db_next;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;

    logic       slot_end, row_hit, scan_v, same, accept, press, blank;
    logic [1:0] col_idx;
    logic [3:0] scan_code, digit;

    assign rowwrite = ~(4'b0001 << row);
    assign grounds  = 4'b0001 << idx;
    assign slot_end = (scan_cnt == SCAN_LAST);
    assign row_hit  = (colread != 4'hF);

    always_comb begin
        col_idx = 2'd0;
        if (!colread[3]) col_idx = 2'd3;
        if (!colread[2]) col_idx = 2'd2;
        if (!colread[1]) col_idx = 2'd1;
        if (!colread[0]) col_idx = 2'd0;
    end

    // Scan candidate so far, including the row being sampled now
    always_comb begin
        scan_v    = (row == 2'd0) ? row_hit : (cand_v | row_hit);
        scan_code = (row != 2'd0 && cand_v) ? cand_code
                                            : key_code({row, col_idx});
        same      = (scan_v == prev_v) && (!scan_v || scan_code == prev_code);
        db_next   = !same ? DW'(1)
                  : (db_cnt == DB_MAX) ? db_cnt : db_cnt + DW'(1);
        accept    = slot_end && (row == 2'd3) && (db_next >= DB_MAX)
                  && ((scan_v != stable_v)
                      || (scan_v && scan_code != stable_code));
        press     = accept && scan_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            row         <= 2'd0;
            cand_v      <= 1'b0;
            cand_code   <= 4'h0;
            prev_v      <= 1'b0;
            prev_code   <= 4'h0;
            db_cnt      <= '0;
            stable_v    <= 1'b0;
            stable_code <= 4'h0;
            keyout      <= 4'h0;
            ready       <= 1'b0;
        end else begin
            if (slot_end) begin
                scan_cnt  <= '0;
                row       <= row + 2'd1;
                cand_v    <= scan_v;
                cand_code <= scan_code;
                if (row == 2'd3) begin
                    prev_v    <= scan_v;
                    prev_code <= scan_code;
                    db_cnt    <= db_next;
                end
                if (accept) begin
                    stable_v    <= scan_v;
                    stable_code <= scan_code;
                end
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            if (press && !ready) begin
                keyout <= scan_code;
                ready  <= 1'b1;
            end else if (ready && ack) begin
                ready <= 1'b0;
            end
        end
    end

    assign digit = datain[4*idx +: 4];

    always_comb begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd1:    blank = (datain[15:4] == 12'h000);
            2'd2:    blank = (datain[15:8] == 8'h00);
            2'd3:    blank = (datain[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
            display <= 7'h7E;
        end else begin
            display <= blank ? 7'h00 : seg(digit);
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_keypad_display_io.sv
// Randomized bench for keypad_display_io with a behavioural model of scan, debounce,
// handshake and display; directed literal checks pin the model.
module tb_keypad_display_io;
    localparam int SD = 4;
    localparam int DB = 2;
    localparam int RD = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  rowwrite;
    logic [3:0]  colread;
    logic [3:0]  keyout;
    logic        ready;
    logic        ack = 0;
    logic [15:0] datain = 16'h0000;
    logic [3:0]  grounds;
    logic [6:0]  display;
    logic [3:0]  pressed [4];

    int errors = 0;
    int checks = 0;

    keypad_display_io #(
        .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .rst(rst), .rowwrite(rowwrite), .colread(colread),
        .keyout(keyout), .ready(ready), .ack(ack), .datain(datain),
        .grounds(grounds), .display(display)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed switch pulls its column low when its row is driven
    always_comb begin
        colread = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rowwrite[r]) colread = colread & ~pressed[r];
    end

    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
        7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Behavioural model
    int  t = 0, dt = 0, m_idx = 0, sc = -1, stable = -1;
    int  hist [$];
    bit  started = 0, m_ready = 0;
    int  m_key = 0;
    logic [6:0] m_disp = 7'h7E;

    function automatic bit is_blank(int i, logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        return (i > 0) && ((d >> (4 * i)) == 0);
`else
        return (i < 0) && (d == 16'hFFFF);
`endif
    endfunction

    always @(posedge clk) begin
        bit rdy0;
        int r;
        bit eq;
        if (rst) begin
            t = 0; dt = 0; m_idx = 0; sc = -1; stable = -1;
            hist.delete();
            m_ready = 0; m_key = 0; m_disp = 7'h7E; started = 1;
        end else begin
            rdy0 = m_ready;
            if (m_ready && ack) m_ready = 0;
            if (t % SD == SD - 1) begin
                r = (t / SD) % 4;
                if (r == 0) sc = -1;
                if (sc < 0)
                    for (int c = 3; c >= 0; c--)
                        if (pressed[r][c]) sc = keymap[r * 4 + c];
                if (r == 3) begin
                    hist.push_back(sc);
                    if (hist.size() > DB) void'(hist.pop_front());
                    eq = (hist.size() == DB);
                    foreach (hist[k]) if (hist[k] != hist[0]) eq = 0;
                    if (eq && hist[0] != stable) begin
                        stable = hist[0];
                        if (stable >= 0 && !rdy0) begin
                            m_ready = 1;
                            m_key = stable;
                        end
                    end
                end
            end
            t++;
            m_disp = is_blank(m_idx, datain) ? 7'h00
                   : segtab[(datain >> (4 * m_idx)) & 16'hF];
            dt++;
            if (dt == RD) begin
                dt = 0;
                m_idx = (m_idx + 1) % 4;
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic do_ack();
        ack = 1;
        cyc(1);
        ack = 0;
    endtask

    initial begin
        logic [3:0] gprev;
        bit found;
        logic [6:0] dexp [4];
        release_all();

        fork
            forever begin
                @(negedge clk);
                if (started) begin
                    chk("rowwrite", rowwrite, ~(4'b0001 << ((t / SD) % 4)) & 4'hF);
                    chk("ready", ready, m_ready);
                    chk("keyout", keyout, m_key);
                    chk("grounds", grounds, 4'b0001 << m_idx);
                    chk("display", display, m_disp);
                end
            end
        join_none

        cyc(2);
        rst = 0;
        chk("rst_rowwrite", rowwrite, 4'b1110);
        chk("rst_ready", ready, 0);
        chk("rst_keyout", keyout, 0);
        chk("rst_grounds", grounds, 4'b0001);
        chk("rst_display", display, 7'h7E);
        cyc(40);

        pressed[1][2] = 1;
        cyc(64);
        chk("key6_ready", ready, 1);
        chk("key6_code", keyout, 6);
        ack = 1;
        cyc(1);
        chk("key6_ack", ready, 0);
        ack = 0;
        cyc(64);
        chk("key6_norepeat", ready, 0);
        release_all();
        cyc(64);

        pressed[3][0] = 1;
        cyc(64);
        chk("keyE_ready", ready, 1);
        chk("keyE_code", keyout, 14);
        release_all();
        cyc(64);
        pressed[2][0] = 1;
        cyc(64);
        chk("key7_dropped_ready", ready, 1);
        chk("key7_dropped_code", keyout, 14);
        do_ack();
        cyc(64);
        chk("key7_held_noevent", ready, 0);
        release_all();
        cyc(64);

        cyc(7);
        pressed[0][0] = 1;
        cyc(16);
        release_all();
        cyc(64);
        chk("glitch_ignored", ready, 0);

        pressed[0][0] = 1;
        pressed[1][1] = 1;
        cyc(64);
        chk("two_keys_ready", ready, 1);
        chk("two_keys_code", keyout, 1);
        do_ack();
        release_all();
        cyc(64);

        datain = 16'h00a2;
        dexp[0] = 7'h6D;
        dexp[1] = 7'h77;
`ifdef LEADING_ZERO_BLANK_EN
        dexp[2] = 7'h00;
        dexp[3] = 7'h00;
`else
        dexp[2] = 7'h7E;
        dexp[3] = 7'h7E;
`endif
        cyc(1);
        gprev = grounds;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (grounds == 4'b0001 && gprev == 4'b1000) found = 1;
            gprev = grounds;
        end
        chk("digit_sync_found", found, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("digit_grounds", grounds, 4'b0001 << k);
            chk("digit_display", display, dexp[k]);
            cyc(3);
        end

        for (int it = 0; it < 60; it++) begin
            int hold;
            datain = 16'($urandom);
            if ($urandom_range(0, 3) == 0) datain = datain & 16'h00FF;
            release_all();
            pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1;
            if ($urandom_range(0, 3) == 0)
                pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1;
            hold = $urandom_range(5, 90);
            for (int c = 0; c < hold; c++) begin
                ack = ($urandom_range(0, 3) == 0);
                cyc(1);
            end
            release_all();
            hold = $urandom_range(0, 60);
            for (int c = 0; c < hold; c++) begin
                ack = ($urandom_range(0, 2) == 0);
                cyc(1);
            end
            if ($urandom_range(0, 9) == 0) begin
                rst = 1;
                cyc($urandom_range(1, 2));
                rst = 0;
            end
        end
        ack = 0;
        release_all();
        cyc(64);

        pressed[2][3] = 1;
        cyc(64);
        chk("keyC_code", keyout, 12);
        chk("keyC_ready", ready, 1);
        rst = 1;
        cyc(1);
        rst = 0;
        chk("midrst_ready", ready, 0);
        chk("midrst_keyout", keyout, 0);
        release_all();
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
